// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and default width for the ALU sequencer
// and the standalone ALU core.
package alu_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_INC = 4'd7;
    localparam logic [3:0] OP_DEC = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result = f(op, a, b) plus carry/borrow.
// Opcodes 9..15 clear the result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum      = '0;
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                sum      = {1'b0, a_i} + {1'b0, b_i};
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                carry_o  = (a_i < b_i);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_NOT: result_o = ~a_i;
            OP_MOV: result_o = b_i;
            OP_INC: begin
                sum      = {1'b0, a_i} + (WIDTH+1)'(1);
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
            end
            OP_DEC: begin
                result_o = a_i - WIDTH'(1);
                carry_o  = (a_i == '0);
            end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Accumulator sequencer: applies one opcode 1..15 times per command.
// Define ALU_SEQ_FLAGS_EN to add carry/zero flag registers and ports.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               CNT_W    = 4,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] acc_out,
    output logic             busy,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             flag_carry,
    output logic             flag_zero,
`endif
    output logic             done
);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             accept;

    assign accept = cmd_valid && cmd_ready;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i     (op_q),
        .a_i      (acc_q),
        .b_i      (b_q),
        .result_o (alu_res),
        .carry_o  (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            acc_q   <= ACC_INIT;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)
                state_d = (cmd_count == '0) ? S_DONE : S_EXEC;
            S_EXEC: if (rem_q == CNT_W'(1))
                state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command fields are captured only at accept; EXEC uses the copies.
    always_comb begin
        op_d  = op_q;
        b_d   = b_q;
        rem_d = rem_q;
        acc_d = acc_q;
        if (accept) begin
            op_d  = cmd_op;
            b_d   = cmd_operand;
            rem_d = cmd_count;
        end
        if (state_q == S_EXEC) begin
            acc_d = alu_res;
            rem_d = rem_q - CNT_W'(1);
        end
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        acc_out   = acc_q;
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic carry_q, carry_d;
    logic zero_q, zero_d;

    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (state_q == S_EXEC) begin
            carry_d = alu_carry;
            zero_d  = (alu_res == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign flag_carry = carry_q;
    assign flag_zero  = zero_q;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

endmodule
